// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the countdown_timer block of the anti-theft
// alarm datapath.
//   state_t          : countdown FSM states (IDLE, WAIT1, WAIT2, RUN, DONE)
//   INT_*            : interval selector codes presented to the parameter store
//   DEF_VAL_W        : default width of the duration value / remaining count
// -----------------------------------------------------------------------------
package timer_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT1 = 3'd1,
      WAIT2 = 3'd2,
      RUN   = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [1:0] INT_ARM_DELAY       = 2'b00;
   localparam logic [1:0] INT_DRIVER_DELAY    = 2'b01;
   localparam logic [1:0] INT_PASSENGER_DELAY = 2'b10;
   localparam logic [1:0] INT_ALARM_ON        = 2'b11;

   localparam int DEF_VAL_W = 4;

endpackage : timer_pkg

// File: rtl/countdown_timer_if.sv
// -----------------------------------------------------------------------------
// countdown_timer_if
// Signal bundle between the alarm FSM / parameter store (master) and the
// countdown timer (slave).
//   start_timer   : single-cycle start/restart request
//   interval_in   : requested interval code, sampled with start_timer
//   value         : registered duration returned by the parameter store
//   pause         : freeze counting while in RUN (only with TIMER_PAUSE_EN)
//   interval      : registered selector driven to the parameter store
//   busy          : timer active, from the start edge until expiry
//   remaining     : seconds left, 0 when idle
//   one_hz_enable : one-cycle tick pulse while counting
//   expired       : one-cycle completion pulse
// Optional feature macro: TIMER_PAUSE_EN adds the pause signal.
// -----------------------------------------------------------------------------
interface countdown_timer_if #(
   parameter int VAL_W = timer_pkg::DEF_VAL_W
) ();

   logic             start_timer;
   logic [1:0]       interval_in;
   logic [VAL_W-1:0] value;
`ifdef TIMER_PAUSE_EN
   logic             pause;
`endif
   logic [1:0]       interval;
   logic             busy;
   logic [VAL_W-1:0] remaining;
   logic             one_hz_enable;
   logic             expired;

   modport master (
      output start_timer, interval_in, value,
`ifdef TIMER_PAUSE_EN
      output pause,
`endif
      input  interval, busy, remaining, one_hz_enable, expired
   );

   modport slave (
      input  start_timer, interval_in, value,
`ifdef TIMER_PAUSE_EN
      input  pause,
`endif
      output interval, busy, remaining, one_hz_enable, expired
   );

endinterface : countdown_timer_if

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Clearable modulo-TICK_DIV counter producing the one-second tick.
//   clock  : system clock
//   reset  : synchronous, active-high reset
//   clear  : force the count to zero (takes priority over enable)
//   enable : advance the count this cycle
//   tick   : high during the enabled cycle in which the count is TICK_DIV-1
// -----------------------------------------------------------------------------
module tick_divider #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int               CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count_q;

   // NOTE: clocked state is always written with non-blocking assignments so
   // every register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count_q <= '0;
      end else if (enable) begin
         if (count_q == LAST) count_q <= '0;
         else                 count_q <= count_q + 1'b1;
      end
   end

   assign tick = enable && !clear && (count_q == LAST);

endmodule : tick_divider

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// Seconds countdown for the anti-theft alarm. A start request latches the
// interval selector, waits for the parameter store to return the duration,
// then counts it down once per tick and pulses expired at zero.
//   clock : system clock
//   reset : synchronous, active-high reset
//   bus   : countdown_timer_if.slave (start/interval request, store value,
//           interval/busy/remaining/one_hz_enable/expired status)
// Parameters:
//   TICK_DIV : clock cycles per one-second tick (>= 2)
//   VAL_W    : width of duration and remaining count
// Optional feature macro: TIMER_PAUSE_EN (pause input freezes RUN counting).
// -----------------------------------------------------------------------------
module countdown_timer
   import timer_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int VAL_W    = DEF_VAL_W
) (
   input  logic               clock,
   input  logic               reset,
   countdown_timer_if.slave   bus
);

   state_t           state_q, state_d;
   logic [1:0]       interval_q, interval_d;
   logic [VAL_W-1:0] remaining_q, remaining_d;
   logic             loaded_q, loaded_d;
   logic             hold;
   logic             tick;
   logic             div_clear;
   logic             div_enable;

`ifdef TIMER_PAUSE_EN
   assign hold = bus.pause;
`else
   assign hold = 1'b0;
`endif

   // The divider is held at zero outside RUN and during the load cycle, so
   // the first tick lands TICK_DIV cycles after the new count is visible.
   assign div_clear  = (state_q != RUN) || loaded_q;
   assign div_enable = (state_q == RUN) && !hold;

   tick_divider #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_divider (
      .clock  (clock),
      .reset  (reset),
      .clear  (div_clear),
      .enable (div_enable),
      .tick   (tick)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         interval_q  <= INT_ARM_DELAY;
         remaining_q <= '0;
         loaded_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         interval_q  <= interval_d;
         remaining_q <= remaining_d;
         loaded_q    <= loaded_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      interval_d  = interval_q;
      remaining_d = remaining_q;
      loaded_d    = 1'b0;

      if (bus.start_timer) begin
         // Start and restart share one path; a DONE cycle still shows its
         // expired pulse because that output decodes the current state.
         state_d    = WAIT1;
         interval_d = bus.interval_in;
      end else begin
         unique case (state_q)
            IDLE:  state_d = IDLE;
            WAIT1: state_d = WAIT2;
            WAIT2: begin
               state_d     = RUN;
               remaining_d = bus.value;
               loaded_d    = 1'b1;
            end
            RUN: begin
               if (hold) begin
                  loaded_d = loaded_q;
               end else if (remaining_q == '0) begin
                  state_d = DONE;
               end else if (tick) begin
                  if (remaining_q == VAL_W'(1)) begin
                     remaining_d = '0;
                     state_d     = DONE;
                  end else begin
                     remaining_d = remaining_q - 1'b1;
                  end
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.interval      = interval_q;
   assign bus.busy          = (state_q != IDLE);
   assign bus.remaining     = remaining_q;
   assign bus.one_hz_enable = tick;
   assign bus.expired       = (state_q == DONE);

endmodule : countdown_timer
